// File: rtl/screen_pkg.sv
// Shared types and constants for the screen shuffler: FSM states and LFSR taps.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package screen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Fibonacci tap masks, bit (t-1) set for each tap t
    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;  // 8,6,5,4
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;  // 16,14,13,11
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // 32,22,2,1

    function automatic logic [31:0] tap_mask(input int w);
        case (w)
            8:       return TAPS_8;
            16:      return TAPS_16;
            32:      return TAPS_32;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/screen_shuffler_if.sv
// Controller <-> shuffler bundle: start request, uniqueness mode, committed screens.
// Latency: n/a (wires only).
// Backpressure: none; Busy/Done report run progress, Start is a level request.
interface screen_shuffler_if #(
    parameter int N_SCREENS = 4,
    parameter int SYM_W     = 2
);
    logic                       Start;
    logic                       Unique;
    logic [N_SCREENS*SYM_W-1:0] Screens;
    logic                       Busy;
    logic                       Done;

    modport master (output Start, output Unique, input Screens, input Busy, input Done);
    modport slave  (input Start, input Unique, output Screens, output Busy, output Done);
endinterface

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR, shifts left with the tap parity entering bit 0.
// Latency: new value every cycle; reloads the seed on Rst.
// Backpressure: none, never stalls.
module lfsr_gen
    import screen_pkg::*;
#(
    parameter int          LFSR_W = 16,
    parameter logic [31:0] SEED   = 32'h0000_ACE1
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic [LFSR_W-1:0] Q
);
    if (LFSR_W != 8 && LFSR_W != 16 && LFSR_W != 32) begin : g_bad_width
        $error("lfsr_gen: LFSR_W must be 8, 16 or 32");
    end

    localparam logic [LFSR_W-1:0] SEED_W  = SEED[LFSR_W-1:0];
    // an all-zero state would lock up, so substitute 1
    localparam logic [LFSR_W-1:0] RST_VAL = (SEED_W == '0) ? LFSR_W'(1) : SEED_W;
    localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(tap_mask(LFSR_W));

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // next state: shift left, feed back parity of tapped bits
    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    end

    // state register, seeded on reset
    always_ff @(posedge Clk) begin
        if (Rst) lfsr_q <= RST_VAL;
        else     lfsr_q <= lfsr_d;
    end

    assign Q = lfsr_q;
endmodule

// File: rtl/screen_shuffler.sv
// Fills N_SCREENS slots with LFSR symbols, optionally all distinct, then commits atomically.
// Latency: N_SCREENS+1 edges best case, N_SCREENS*(MAX_RETRY+1)+1 worst case from the start edge.
// Backpressure: none; Start edges while Busy or in the commit cycle are dropped.
module screen_shuffler
    import screen_pkg::*;
#(
    parameter int          N_SCREENS = 4,
    parameter int          SYM_W     = 2,
    parameter int          LFSR_W    = 16,
    parameter logic [31:0] SEED      = 32'h0000_ACE1,
    parameter int          MAX_RETRY = 7
) (
    input  logic           Clk,
    input  logic           Rst,
    screen_shuffler_if.slave bus
);
    localparam int NSYM  = 1 << SYM_W;
    localparam int IDX_W = (N_SCREENS > 1) ? $clog2(N_SCREENS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SCREENS - 1);
    localparam logic [3:0]       MAX_R    = 4'(MAX_RETRY);

    if (N_SCREENS < 1 || N_SCREENS > NSYM) begin : g_bad_count
        $error("screen_shuffler: N_SCREENS must be 1..2**SYM_W");
    end

    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_unused;
    logic [SYM_W-1:0]  cand;
    logic [SYM_W-1:0]  fb;

    lfsr_gen #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
        .Clk (Clk),
        .Rst (Rst),
        .Q   (lfsr_q)
    );

    assign cand        = lfsr_q[SYM_W-1:0];
    assign lfsr_unused = ^lfsr_q[LFSR_W-1:SYM_W];

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [3:0]                 retry_q, retry_d;
    logic [NSYM-1:0]            used_q, used_d;
    logic [SYM_W-1:0]           slot_q [N_SCREENS];
    logic [SYM_W-1:0]           slot_d [N_SCREENS];
    logic                       uniq_q, uniq_d;
    logic                       start_q;
    logic                       start_rise;
    logic [N_SCREENS*SYM_W-1:0] screens_q, screens_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       wr;
    logic [SYM_W-1:0]           wr_sym;

    assign start_rise = bus.Start & ~start_q;

    // fallback symbol: lowest-index value not yet used in this run
    always_comb begin
        fb = '0;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (!used_q[i]) fb = SYM_W'(i);
        end
    end

    // next state and outputs
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        used_d    = used_q;
        slot_d    = slot_q;
        uniq_d    = uniq_q;
        screens_d = screens_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr        = 1'b0;
        wr_sym    = cand;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    retry_d = '0;
                    used_d  = '0;
                    uniq_d  = bus.Unique;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (!uniq_q || !used_q[cand]) begin
                    wr = 1'b1;
                end else if (retry_q < MAX_R) begin
                    retry_d = retry_q + 4'd1;
                end else begin
                    wr     = 1'b1;
                    wr_sym = fb;
                end
                if (wr) begin
                    slot_d[idx_q]  = wr_sym;
                    used_d[wr_sym] = 1'b1;
                    retry_d        = '0;
                    if (idx_q == LAST_IDX) state_d = COMMIT;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            COMMIT: begin
                for (int i = 0; i < N_SCREENS; i++) begin
                    screens_d[i*SYM_W +: SYM_W] = slot_q[i];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; the edge detector samples Start every cycle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            used_q    <= '0;
            slot_q    <= '{default: '0};
            uniq_q    <= 1'b0;
            start_q   <= 1'b0;
            screens_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            used_q    <= used_d;
            slot_q    <= slot_d;
            uniq_q    <= uniq_d;
            start_q   <= bus.Start;
            screens_q <= screens_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.Screens = screens_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
endmodule

// File: doc/screen_shuffler.md
# screen_shuffler

Parametrised generator that fills N display screens with pseudo-random symbols on a start request. It can enforce that all screens show distinct values. It sits between the game controller and the screen decoders. It replaces the fixed four-screen, 2-bit chooser with:
- configurable screen count and symbol width,
- a bounded-latency duplicate-rejection scheme,
- an atomic output commit with a busy/done handshake.

## Interface
Parameters:
- N_SCREENS, 4, number of screens generated per run (1..2^SYM_W when Unique=1)
- SYM_W, 2, bits per screen symbol (1..6)
- LFSR_W, 16, LFSR length; legal values are 8, 16 or 32
- SEED, 16'hACE1, LFSR reset value (low LFSR_W bits used); a zero seed is replaced by 1
- MAX_RETRY, 7, rejected draws allowed per slot before fallback (0..15)

Ports:
- Clk  in  1  single clock; all logic on posedge
- Rst  in  1  synchronous, active-high reset
- Start  in  1  level request; a run begins on its rising edge (0→1 between samples)
- Unique  in  1  1 = all screens must differ, 0 = repeats allowed; sampled at run start
- Screens  out  N_SCREENS*SYM_W  slot i occupies bits [i*SYM_W +: SYM_W]
- Busy  out  1  high while a run is in progress
- Done  out  1  one-cycle pulse when Screens has just been updated

## Operation
- The LFSR free-runs every cycle from reset, including when idle, so Start timing adds entropy.
  - Feedback is Fibonacci with taps from the package: 8: 8,6,5,4; 16: 16,14,13,11; 32: 32,22,2,1.
  - Candidate symbol = LFSR[SYM_W-1:0] in the current cycle.
- FSM states are IDLE, DRAW and COMMIT.
- IDLE:
  - On a Start rising edge: Busy←1, idx←0, retry←0, used mask (2^SYM_W bits)←0, uniq_q←Unique. Go to DRAW.
  - Otherwise stay in IDLE.
- DRAW, evaluated each cycle:
  - If uniq_q=0 or used[cand]=0: slot[idx]←cand, used[cand]←1, retry←0.
  - Else if retry<MAX_RETRY: retry←retry+1; no write.
  - Else: slot[idx]←fb, used[fb]←1, retry←0. fb is the lowest-index clear bit of used, via a priority encoder.
  - A write when idx=N_SCREENS-1 moves the FSM to COMMIT; any other write increments idx.
- COMMIT: Screens←all slots in one cycle, Done←1, Busy←0. Go to IDLE.
- Screens holds its previous value for the whole run; it is never partially updated.
- Start edges seen while Busy, or in the COMMIT cycle, are ignored. The edge-detect register updates every cycle, so a held Start never retriggers.
- Rst, including mid-run:
  - Screens=0, Busy=0, Done=0, state IDLE, idx/retry/used/slots=0.
  - LFSR←SEED, and the edge register←0.
  - If Start is high at the first post-reset sample, that counts as a rising edge.
- Elaboration fails if N_SCREENS > 2^SYM_W, or if LFSR_W is not in {8,16,32}.

## Timing
- Edge k: Start rising edge sampled → Busy=1 from edge k.
- Best case (no rejections): final slot written at edge k+N_SCREENS; COMMIT at edge k+N_SCREENS+1, so Screens is valid and Done=1 in that cycle.
- Worst case: COMMIT at edge k+N_SCREENS*(MAX_RETRY+1)+1.
- With Unique=0, latency is always exactly N_SCREENS+1 edges.
- Done is high for exactly one cycle. Busy falls on the same edge Done rises.
- Earliest restart: a new Start edge sampled in the cycle after COMMIT.

## Structure
- Package screen_pkg holds:
  - the FSM state enum (IDLE, DRAW, COMMIT),
  - the tap-mask constants per LFSR_W,
  - a function returning the tap mask for a given width.
- Sub-module lfsr_gen(Clk, Rst, Q) with parameters LFSR_W and SEED. It is free-running and instantiated once.
- Slot storage, used mask, priority encoder and FSM stay in screen_shuffler.

## Test plan
- Reset, then N_SCREENS=4, SYM_W=2, Unique=1, one Start pulse:
  - Screens is a permutation of {0,1,2,3}.
  - Done pulses once, within ≤33 edges of the start edge.
  - Busy is high throughout the run.
- Unique=0, N_SCREENS=4:
  - Done arrives exactly 5 edges after the start edge.
  - Screens equals the 4 consecutive LFSR[1:0] values captured by the reference model.
- MAX_RETRY=0, N_SCREENS=4, SYM_W=2, Unique=1: every collision writes the lowest unused value; the result matches a model with 4+1 edge latency.
- Start held high for 100 cycles: exactly one run and one Done pulse. Extra toggles while Busy cause no additional runs.
- Rst asserted mid-DRAW at edge k+2: all outputs go to 0 at the next edge, the LFSR reloads SEED, and a following Start reproduces the first run bit-for-bit.
- Screens stability: an observer checks that Screens only changes in cycles where Done=1.
